// File: rtl/config_fetch_seq_pkg.sv
// Shared definitions for the per-time-step neuron config fetch sequencer.
// Optional learning fields (port A) are enabled with CONFIG_FETCH_LRN_EN.
package config_fetch_seq_pkg;

   // Sequencer states: wait for start, walk the neurons, drain the output buffer
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Two entries cover the single-cycle ROM read latency at full throughput
   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W = 2;

   // Packed width of the port B fields: NurnType, RandTh, Th_Mask, RstPot, SpikeAER
   function automatic int rec_b_width(input int dsize, input int aer_w);
      return 2 + 2 * dsize + aer_w;
   endfunction

`ifdef CONFIG_FETCH_LRN_EN
   // Packed width of the port A fields: LTP/LTD windows, LTP/LTD rates, bias mode
   function automatic int rec_a_width(input int stdp_w, input int dsize);
      return 2 * stdp_w + 2 * dsize + 1;
   endfunction
`endif

endpackage

// File: rtl/config_fetch_seq_fifo.sv
// Two-entry synchronous record FIFO with occupancy count and valid/ready read side.
// Storage is cleared on reset so the head reads as zero until the first write.
module cfg_rec_fifo
   import config_fetch_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   output logic                  rd_vld,
   input  logic                  rd_rdy,
   output logic [WIDTH-1:0]      rd_data,
   output logic [FIFO_CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign rd_vld  = (count != '0);
   assign do_pop  = rd_vld & rd_rdy;
   assign do_push = wr_en & ((count != FIFO_CNT_W'(FIFO_DEPTH)) | do_pop);
   assign rd_data = mem[rd_ptr];

   // Storage, pointers and count; a simultaneous push and pop leaves the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/config_fetch_seq.sv
// Per-time-step neuron config fetch sequencer: walks neuron indices, reads the
// config ROM, buffers returned fields and hands one record per neuron downstream.
// Define CONFIG_FETCH_LRN_EN to also drive port A and carry the learning fields.
module config_fetch_seq
   import config_fetch_seq_pkg::*;
#(
   parameter int NUM_NURNS          = 256,
   parameter int NURN_CNT_BIT_WIDTH = 8,
   parameter int DSIZE              = 16,
`ifdef CONFIG_FETCH_LRN_EN
   parameter int STDP_WIN_BIT_WIDTH = 8,
`endif
   parameter int AER_BIT_WIDTH      = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          start_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [NURN_CNT_BIT_WIDTH-1:0] Addr_Config_B_o,
   output logic                          rdEn_Config_B_o,
   input  logic                          NurnType_i,
   input  logic                          RandTh_i,
   input  logic [DSIZE-1:0]              Th_Mask_i,
   input  logic [DSIZE-1:0]              RstPot_i,
   input  logic [AER_BIT_WIDTH-1:0]      SpikeAER_i,
`ifdef CONFIG_FETCH_LRN_EN
   output logic [NURN_CNT_BIT_WIDTH-1:0] Addr_Config_A_o,
   output logic                          rdEn_Config_A_o,
   input  logic [STDP_WIN_BIT_WIDTH-1:0] LTP_Win_i,
   input  logic [STDP_WIN_BIT_WIDTH-1:0] LTD_Win_i,
   input  logic [DSIZE-1:0]              LTP_LrnRt_i,
   input  logic [DSIZE-1:0]              LTD_LrnRt_i,
   input  logic                          biasLrnMode_i,
   output logic [STDP_WIN_BIT_WIDTH-1:0] cfg_LTP_Win_o,
   output logic [STDP_WIN_BIT_WIDTH-1:0] cfg_LTD_Win_o,
   output logic [DSIZE-1:0]              cfg_LTP_LrnRt_o,
   output logic [DSIZE-1:0]              cfg_LTD_LrnRt_o,
   output logic                          cfg_biasLrnMode_o,
`endif
   output logic                          cfg_vld_o,
   input  logic                          cfg_rdy_i,
   output logic [NURN_CNT_BIT_WIDTH-1:0] cfg_nurn_id_o,
   output logic                          cfg_NurnType_o,
   output logic                          cfg_RandTh_o,
   output logic [DSIZE-1:0]              cfg_Th_Mask_o,
   output logic [DSIZE-1:0]              cfg_RstPot_o,
   output logic [AER_BIT_WIDTH-1:0]      cfg_SpikeAER_o
);

   localparam int REC_B_W = rec_b_width(DSIZE, AER_BIT_WIDTH);
`ifdef CONFIG_FETCH_LRN_EN
   localparam int REC_W   = NURN_CNT_BIT_WIDTH + REC_B_W + rec_a_width(STDP_WIN_BIT_WIDTH, DSIZE);
`else
   localparam int REC_W   = NURN_CNT_BIT_WIDTH + REC_B_W;
`endif
   localparam logic [NURN_CNT_BIT_WIDTH-1:0] LAST_IDX = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);

   state_t                        state;
   state_t                        state_nxt;
   logic [NURN_CNT_BIT_WIDTH-1:0] idx;
   logic [NURN_CNT_BIT_WIDTH-1:0] idx_nxt;
   logic [NURN_CNT_BIT_WIDTH-1:0] tag;
   logic                          inflight;
   logic                          issue;
   logic                          pop;
   logic                          done_q;
   logic                          done_nxt;
   logic [2:0]                    occupancy;
   logic [FIFO_CNT_W-1:0]         fifo_count;
   logic [REC_W-1:0]              rec_in;
   logic [REC_W-1:0]              rec_out;

   // Slots already committed: buffered records plus the one in flight, minus the one leaving now
   assign pop       = cfg_vld_o & cfg_rdy_i;
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

   // Read enable stays high for the whole walk so the ROM output latch passes data through
   assign busy_o          = (state != ST_IDLE);
   assign rdEn_Config_B_o = (state != ST_IDLE);
   assign Addr_Config_B_o = idx;
   assign done_o          = done_q;
`ifdef CONFIG_FETCH_LRN_EN
   assign rdEn_Config_A_o = rdEn_Config_B_o;
   assign Addr_Config_A_o = Addr_Config_B_o;
`endif

   // Next-state, index advance and issue decision
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      issue     = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               state_nxt = ST_RUN;
               idx_nxt   = '0;
            end
         end
         ST_RUN: begin
            if (occupancy < 3'd2) begin
               issue = 1'b1;
               if (idx == LAST_IDX) begin
                  state_nxt = ST_DRAIN;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (!inflight && (fifo_count == '0)) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register, neuron index and the one-cycle done pulse
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= ST_IDLE;
         idx    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         done_q <= done_nxt;
      end
   end

   // Tag each issued index so it travels with its ROM data into the FIFO one cycle later
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         inflight <= 1'b0;
         tag      <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            tag <= idx;
         end
      end
   end

`ifdef CONFIG_FETCH_LRN_EN
   assign rec_in = {tag, NurnType_i, RandTh_i, Th_Mask_i, RstPot_i, SpikeAER_i,
                    LTP_Win_i, LTD_Win_i, LTP_LrnRt_i, LTD_LrnRt_i, biasLrnMode_i};
   assign {cfg_nurn_id_o, cfg_NurnType_o, cfg_RandTh_o, cfg_Th_Mask_o, cfg_RstPot_o,
           cfg_SpikeAER_o, cfg_LTP_Win_o, cfg_LTD_Win_o, cfg_LTP_LrnRt_o,
           cfg_LTD_LrnRt_o, cfg_biasLrnMode_o} = rec_out;
`else
   assign rec_in = {tag, NurnType_i, RandTh_i, Th_Mask_i, RstPot_i, SpikeAER_i};
   assign {cfg_nurn_id_o, cfg_NurnType_o, cfg_RandTh_o, cfg_Th_Mask_o, cfg_RstPot_o,
           cfg_SpikeAER_o} = rec_out;
`endif

   cfg_rec_fifo #(
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .wr_en   (inflight),
      .wr_data (rec_in),
      .rd_vld  (cfg_vld_o),
      .rd_rdy  (cfg_rdy_i),
      .rd_data (rec_out),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_config_fetch_seq.sv
// Self-checking bench for config_fetch_seq: table-driven start/backpressure vectors,
// full-walk scoreboards, busy-restart rejection and asynchronous mid-walk reset.
// Learning-field checks are compiled in when CONFIG_FETCH_LRN_EN is defined.
module tb_config_fetch_seq;

   localparam int NUM = 256;
   localparam int NW  = 8;
   localparam int DS  = 16;
   localparam int AW  = 32;
   localparam int SW  = 8;

   logic          clk = 1'b0;
   logic          rst_n_i;
   logic          start_i;
   logic          busy_o;
   logic          done_o;
   logic [NW-1:0] Addr_Config_B_o;
   logic          rdEn_Config_B_o;
   logic          NurnType_i;
   logic          RandTh_i;
   logic [DS-1:0] Th_Mask_i;
   logic [DS-1:0] RstPot_i;
   logic [AW-1:0] SpikeAER_i;
   logic          cfg_vld_o;
   logic          cfg_rdy_i;
   logic [NW-1:0] cfg_nurn_id_o;
   logic          cfg_NurnType_o;
   logic          cfg_RandTh_o;
   logic [DS-1:0] cfg_Th_Mask_o;
   logic [DS-1:0] cfg_RstPot_o;
   logic [AW-1:0] cfg_SpikeAER_o;
`ifdef CONFIG_FETCH_LRN_EN
   logic [NW-1:0] Addr_Config_A_o;
   logic          rdEn_Config_A_o;
   logic [SW-1:0] LTP_Win_i;
   logic [SW-1:0] LTD_Win_i;
   logic [DS-1:0] LTP_LrnRt_i;
   logic [DS-1:0] LTD_LrnRt_i;
   logic          biasLrnMode_i;
   logic [SW-1:0] cfg_LTP_Win_o;
   logic [SW-1:0] cfg_LTD_Win_o;
   logic [DS-1:0] cfg_LTP_LrnRt_o;
   logic [DS-1:0] cfg_LTD_LrnRt_o;
   logic          cfg_biasLrnMode_o;
   logic [NW-1:0] rom_addr_a = '0;
`endif

   logic [NW-1:0] rom_addr_b = '0;
   int            n_checks   = 0;
   int            n_fail     = 0;
   int            done_seen  = 0;

   typedef struct {
      logic start;
      logic rdy;
      logic exp_busy;
      logic exp_vld;
      int   exp_id;
      int   exp_addr;
      logic exp_rden;
      logic exp_done;
   } vec_t;

   vec_t vecs [15];

   always #5 clk = ~clk;

   // Reference config contents, indexed by neuron
   function automatic logic [DS-1:0] exp_th(input int i);
      return DS'(32'h0000_C000 | i);
   endfunction
   function automatic logic [DS-1:0] exp_rst(input int i);
      return DS'(32'h0000_0F00 + 3 * i);
   endfunction
   function automatic logic [AW-1:0] exp_aer(input int i);
      return AW'(32'hA000_0000 + i);
   endfunction
   function automatic logic exp_type(input int i);
      return 1'(i & 1);
   endfunction
   function automatic logic exp_rand(input int i);
      return 1'((i >> 1) & 1);
   endfunction
`ifdef CONFIG_FETCH_LRN_EN
   function automatic logic [SW-1:0] exp_ltp_win(input int i);
      return SW'(i & 8'hFF);
   endfunction
   function automatic logic [SW-1:0] exp_ltd_win(input int i);
      return SW'(255 - i);
   endfunction
   function automatic logic [DS-1:0] exp_ltp_rt(input int i);
      return DS'(32'h0000_0200 + i);
   endfunction
   function automatic logic [DS-1:0] exp_ltd_rt(input int i);
      return DS'(32'h0000_5555 ^ i);
   endfunction
   function automatic logic exp_bias(input int i);
      return 1'((i >> 2) & 1);
   endfunction
`endif

   // ROM model: address registered at the clock edge, data presented the following cycle
   always @(posedge clk) begin
      rom_addr_b <= Addr_Config_B_o;
`ifdef CONFIG_FETCH_LRN_EN
      rom_addr_a <= Addr_Config_A_o;
`endif
   end

   assign NurnType_i = exp_type(int'(rom_addr_b));
   assign RandTh_i   = exp_rand(int'(rom_addr_b));
   assign Th_Mask_i  = exp_th(int'(rom_addr_b));
   assign RstPot_i   = exp_rst(int'(rom_addr_b));
   assign SpikeAER_i = exp_aer(int'(rom_addr_b));
`ifdef CONFIG_FETCH_LRN_EN
   assign LTP_Win_i     = exp_ltp_win(int'(rom_addr_a));
   assign LTD_Win_i     = exp_ltd_win(int'(rom_addr_a));
   assign LTP_LrnRt_i   = exp_ltp_rt(int'(rom_addr_a));
   assign LTD_LrnRt_i   = exp_ltd_rt(int'(rom_addr_a));
   assign biasLrnMode_i = exp_bias(int'(rom_addr_a));
`endif

   config_fetch_seq #(
      .NUM_NURNS          (NUM),
      .NURN_CNT_BIT_WIDTH (NW),
      .DSIZE              (DS),
`ifdef CONFIG_FETCH_LRN_EN
      .STDP_WIN_BIT_WIDTH (SW),
`endif
      .AER_BIT_WIDTH      (AW)
   ) dut (
      .clk_i             (clk),
      .rst_n_i           (rst_n_i),
      .start_i           (start_i),
      .busy_o            (busy_o),
      .done_o            (done_o),
      .Addr_Config_B_o   (Addr_Config_B_o),
      .rdEn_Config_B_o   (rdEn_Config_B_o),
      .NurnType_i        (NurnType_i),
      .RandTh_i          (RandTh_i),
      .Th_Mask_i         (Th_Mask_i),
      .RstPot_i          (RstPot_i),
      .SpikeAER_i        (SpikeAER_i),
`ifdef CONFIG_FETCH_LRN_EN
      .Addr_Config_A_o   (Addr_Config_A_o),
      .rdEn_Config_A_o   (rdEn_Config_A_o),
      .LTP_Win_i         (LTP_Win_i),
      .LTD_Win_i         (LTD_Win_i),
      .LTP_LrnRt_i       (LTP_LrnRt_i),
      .LTD_LrnRt_i       (LTD_LrnRt_i),
      .biasLrnMode_i     (biasLrnMode_i),
      .cfg_LTP_Win_o     (cfg_LTP_Win_o),
      .cfg_LTD_Win_o     (cfg_LTD_Win_o),
      .cfg_LTP_LrnRt_o   (cfg_LTP_LrnRt_o),
      .cfg_LTD_LrnRt_o   (cfg_LTD_LrnRt_o),
      .cfg_biasLrnMode_o (cfg_biasLrnMode_o),
`endif
      .cfg_vld_o         (cfg_vld_o),
      .cfg_rdy_i         (cfg_rdy_i),
      .cfg_nurn_id_o     (cfg_nurn_id_o),
      .cfg_NurnType_o    (cfg_NurnType_o),
      .cfg_RandTh_o      (cfg_RandTh_o),
      .cfg_Th_Mask_o     (cfg_Th_Mask_o),
      .cfg_RstPot_o      (cfg_RstPot_o),
      .cfg_SpikeAER_o    (cfg_SpikeAER_o)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge, where outputs are sampled and inputs changed
   task automatic tick();
      @(negedge clk);
      if (done_o) done_seen++;
`ifdef CONFIG_FETCH_LRN_EN
      checkOutput("rden_a_mirror", 64'(rdEn_Config_A_o), 64'(rdEn_Config_B_o));
      checkOutput("addr_a_mirror", 64'(Addr_Config_A_o), 64'(Addr_Config_B_o));
`endif
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_busy"},  64'(busy_o),          64'(0));
      checkOutput({tag, "_done"},  64'(done_o),          64'(0));
      checkOutput({tag, "_rden"},  64'(rdEn_Config_B_o), 64'(0));
      checkOutput({tag, "_addr"},  64'(Addr_Config_B_o), 64'(0));
      checkOutput({tag, "_vld"},   64'(cfg_vld_o),       64'(0));
      checkOutput({tag, "_id"},    64'(cfg_nurn_id_o),   64'(0));
      checkOutput({tag, "_type"},  64'(cfg_NurnType_o),  64'(0));
      checkOutput({tag, "_rand"},  64'(cfg_RandTh_o),    64'(0));
      checkOutput({tag, "_th"},    64'(cfg_Th_Mask_o),   64'(0));
      checkOutput({tag, "_rst"},   64'(cfg_RstPot_o),    64'(0));
      checkOutput({tag, "_aer"},   64'(cfg_SpikeAER_o),  64'(0));
`ifdef CONFIG_FETCH_LRN_EN
      checkOutput({tag, "_rden_a"},  64'(rdEn_Config_A_o), 64'(0));
      checkOutput({tag, "_ltp_win"}, 64'(cfg_LTP_Win_o),   64'(0));
`endif
   endtask

   task automatic check_record(input int id, input string tag);
      checkOutput({tag, "_id"},   64'(cfg_nurn_id_o),  64'(id));
      checkOutput({tag, "_aer"},  64'(cfg_SpikeAER_o), 64'(exp_aer(id)));
      checkOutput({tag, "_th"},   64'(cfg_Th_Mask_o),  64'(exp_th(id)));
      checkOutput({tag, "_rst"},  64'(cfg_RstPot_o),   64'(exp_rst(id)));
      checkOutput({tag, "_bits"}, 64'({cfg_NurnType_o, cfg_RandTh_o}),
                  64'({exp_type(id), exp_rand(id)}));
`ifdef CONFIG_FETCH_LRN_EN
      checkOutput({tag, "_ltp_win"}, 64'(cfg_LTP_Win_o),   64'(exp_ltp_win(id)));
      checkOutput({tag, "_ltd_win"}, 64'(cfg_LTD_Win_o),   64'(exp_ltd_win(id)));
      checkOutput({tag, "_ltp_rt"},  64'(cfg_LTP_LrnRt_o), 64'(exp_ltp_rt(id)));
      checkOutput({tag, "_ltd_rt"},  64'(cfg_LTD_LrnRt_o), 64'(exp_ltd_rt(id)));
      checkOutput({tag, "_bias"},    64'(cfg_biasLrnMode_o), 64'(exp_bias(id)));
`endif
   endtask

   // One table row: observe this cycle's outputs, then drive this cycle's inputs
   task automatic applyStimulus(input int r);
      tick();
      checkOutput($sformatf("row%0d_busy", r), 64'(busy_o),          64'(vecs[r].exp_busy));
      checkOutput($sformatf("row%0d_vld", r),  64'(cfg_vld_o),       64'(vecs[r].exp_vld));
      checkOutput($sformatf("row%0d_rden", r), 64'(rdEn_Config_B_o), 64'(vecs[r].exp_rden));
      checkOutput($sformatf("row%0d_addr", r), 64'(Addr_Config_B_o), 64'(vecs[r].exp_addr));
      checkOutput($sformatf("row%0d_done", r), 64'(done_o),          64'(vecs[r].exp_done));
      if (vecs[r].exp_vld) check_record(vecs[r].exp_id, $sformatf("row%0d", r));
      start_i   = vecs[r].start;
      cfg_rdy_i = vecs[r].rdy;
   endtask

   // Scoreboard one walk to completion, then check the done/busy tail
   task automatic run_walk(input bit issue_start, input bit random_rdy, input int first_id,
                           input string tag);
      int exp_id = first_id;
      int cycles = 0;
      int done0  = done_seen;
      bit last   = 1'b0;
      if (issue_start) start_i = 1'b1;
      while (!last && cycles < 3000) begin
         tick();
         start_i   = 1'b0;
         cycles++;
         cfg_rdy_i = random_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (cfg_vld_o && cfg_rdy_i) begin
            check_record(exp_id, $sformatf("%s_rec%0d", tag, exp_id));
            if (exp_id == NUM - 1) last = 1'b1;
            exp_id++;
         end
      end
      if (!last) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL %s_timeout: got %0d records, expected %0d", tag, exp_id, NUM);
      end
      tick();
      checkOutput({tag, "_tail_busy"}, 64'(busy_o),    64'(1));
      checkOutput({tag, "_tail_vld"},  64'(cfg_vld_o), 64'(0));
      checkOutput({tag, "_tail_done"}, 64'(done_o),    64'(0));
      tick();
      checkOutput({tag, "_end_busy"},  64'(busy_o),    64'(0));
      checkOutput({tag, "_end_done"},  64'(done_o),    64'(1));
      tick();
      checkOutput({tag, "_done_off"},  64'(done_o),    64'(0));
      checkOutput({tag, "_count"},     64'(exp_id),    64'(NUM));
      checkOutput({tag, "_done_cnt"},  64'(done_seen - done0), 64'(1));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waited;
      int done_before;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 3, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 4, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 3, 5, 1'b1, 1'b0};

      rst_n_i   = 1'b0;
      start_i   = 1'b0;
      cfg_rdy_i = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst_n_i = 1'b1;
      tick();

      $display("[TB] start with backpressure, busy restart attempt, release");
      for (int r = 0; r < 15; r++) begin
         applyStimulus(r);
      end
      run_walk(1'b0, 1'b0, 4, "walk1");

      $display("[TB] full walk with random downstream ready");
      run_walk(1'b1, 1'b1, 0, "rand");

      $display("[TB] asynchronous reset mid-walk");
      done_before = done_seen;
      start_i     = 1'b1;
      waited      = 0;
      do begin
         tick();
         start_i   = 1'b0;
         cfg_rdy_i = 1'b1;
         waited++;
      end while (!(cfg_vld_o && cfg_nurn_id_o == NW'(100)) && waited < 400);
      checkOutput("midwalk_reach_id", 64'(cfg_nurn_id_o), 64'(100));
      #2 rst_n_i = 1'b0;
      #1 check_all_zero("async_rst");
      tick();
      rst_n_i = 1'b1;
      tick();
      checkOutput("async_rst_no_done", 64'(done_seen - done_before), 64'(0));
      check_all_zero("post_rst");
      run_walk(1'b1, 1'b0, 0, "restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
